// File: rtl/filo_stack.sv
// filo_stack: parametrised pointer-addressed LIFO stack.
//
// Push and pop may happen in the same cycle:
//   - On a non-empty stack this replaces the top entry.
//   - On an empty stack the push data bypasses straight to dout_o.
// Pop data is registered and comes with a one-cycle valid strobe.
// The stack also provides occupancy, full/empty/almost-full status and
// sticky overflow/underflow error flags.
//
// Optional feature: define FILO_STACK_PEEK_EN to add an indexed peek port.
//
// Parameters:
//   DEPTH        number of entries (>= 2, any integer)
//   WIDTH        data width
//   AFULL_THRESH almost_full_o asserts when count_o >= AFULL_THRESH (1..DEPTH)
//
// Ports:
//   clk_i, reset_i      clock; synchronous active-high reset
//   push_i, din_i       push din_i onto the top of the stack
//   pop_i               pop the top entry to dout_o
//   clear_err_i         clear the sticky error flags
//   dout_o              registered pop data; holds the last popped value
//   dout_valid_o        one-cycle strobe, high when dout_o was updated
//   top_o               current top entry (0 when empty)
//   count_o             occupancy, 0..DEPTH
//   full_o, empty_o     occupancy status
//   almost_full_o       high when count_o >= AFULL_THRESH
//   overflow_o          sticky: push while full without a pop
//   underflow_o         sticky: pop while empty without a push
//   peek_idx_i          (FILO_STACK_PEEK_EN) peek depth, 0 = top
//   peek_data_o         (FILO_STACK_PEEK_EN) entry at that depth, 0 if invalid
//   peek_valid_o        (FILO_STACK_PEEK_EN) high when peek_idx_i < count_o
module filo_stack #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned AFULL_THRESH = DEPTH - 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  input  logic                       clear_err_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       dout_valid_o,
  output logic [WIDTH-1:0]           top_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic                       overflow_o,
  output logic                       underflow_o
`ifdef FILO_STACK_PEEK_EN
  ,
  input  logic [$clog2(DEPTH)-1:0]   peek_idx_i,
  output logic [WIDTH-1:0]           peek_data_o,
  output logic                       peek_valid_o
`endif
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;

  // Storage and registered state
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q,      count_d;
  logic [WIDTH-1:0] dout_q,       dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q,   overflow_d;
  logic             underflow_q,  underflow_d;

  // Derived pointers/status.
  // The count doubles as the write index; the top entry sits just below it.
  logic          is_full;
  logic          is_empty;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);
  assign wr_idx   = IW'(count_q);
  assign top_idx  = IW'(count_q - CW'(1));

  // Next-state logic
  always_comb begin
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    mem_d        = mem_q;

    // Clear first so that an error event later in this block wins.
    if (clear_err_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end

    case ({push_i, pop_i})
      2'b10: begin
        if (is_full) begin
          overflow_d = 1'b1;
        end else begin
          mem_d[wr_idx] = din_i;
          count_d       = count_q + CW'(1);
        end
      end

      2'b01: begin
        if (is_empty) begin
          underflow_d = 1'b1;
        end else begin
          dout_d       = mem_q[top_idx];
          dout_valid_d = 1'b1;
          count_d      = count_q - CW'(1);
        end
      end

      2'b11: begin
        // Replace the top entry, or bypass when there is nothing stored.
        dout_valid_d = 1'b1;
        if (is_empty) begin
          dout_d = din_i;
        end else begin
          dout_d         = mem_q[top_idx];
          mem_d[top_idx] = din_i;
        end
      end

      default: ;
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage is not reset; writes are suppressed while reset is asserted
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      mem_q <= mem_d;
    end
  end

  // Outputs
  assign dout_o        = dout_q;
  assign dout_valid_o  = dout_valid_q;
  assign count_o       = count_q;
  assign full_o        = is_full;
  assign empty_o       = is_empty;
  assign almost_full_o = (count_q >= CW'(AFULL_THRESH));
  assign overflow_o    = overflow_q;
  assign underflow_o   = underflow_q;
  assign top_o         = is_empty ? '0 : mem_q[top_idx];

`ifdef FILO_STACK_PEEK_EN
  // Indexed read counted down from the top; zero outside the occupied region
  logic [IW-1:0] peek_addr;
  assign peek_valid_o = (CW'(peek_idx_i) < count_q);
  assign peek_addr    = IW'(count_q - CW'(1) - CW'(peek_idx_i));
  assign peek_data_o  = peek_valid_o ? mem_q[peek_addr] : '0;
`endif

endmodule

// File: tb/tb_filo_stack.sv
// tb_filo_stack: directed and randomized checks of filo_stack against a
// queue-based reference model (DEPTH=8, WIDTH=8, AFULL_THRESH=6).
module tb_filo_stack;

  localparam int DEPTH = 8;
  localparam int AFULL = 6;

  logic       clk;
  logic       reset_i;
  logic       push_i;
  logic [7:0] din_i;
  logic       pop_i;
  logic       clear_err_i;
  logic [7:0] dout_o;
  logic       dout_valid_o;
  logic [7:0] top_o;
  logic [3:0] count_o;
  logic       full_o;
  logic       empty_o;
  logic       almost_full_o;
  logic       overflow_o;
  logic       underflow_o;
`ifdef FILO_STACK_PEEK_EN
  logic [2:0] peek_idx_i;
  logic [7:0] peek_data_o;
  logic       peek_valid_o;
`endif

  filo_stack #(.DEPTH(DEPTH), .WIDTH(8), .AFULL_THRESH(AFULL)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .push_i        (push_i),
    .din_i         (din_i),
    .pop_i         (pop_i),
    .clear_err_i   (clear_err_i),
    .dout_o        (dout_o),
    .dout_valid_o  (dout_valid_o),
    .top_o         (top_o),
    .count_o       (count_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .almost_full_o (almost_full_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o)
`ifdef FILO_STACK_PEEK_EN
    ,
    .peek_idx_i    (peek_idx_i),
    .peek_data_o   (peek_data_o),
    .peek_valid_o  (peek_valid_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_ovf;
  logic       m_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    check("count",  32'(count_o),       32'(sz));
    check("empty",  32'(empty_o),       32'(sz == 0));
    check("full",   32'(full_o),        32'(sz == DEPTH));
    check("afull",  32'(almost_full_o), 32'(sz >= AFULL));
    check("top",    32'(top_o),         (sz == 0) ? 32'd0 : 32'(q[sz-1]));
    check("dout",   32'(dout_o),        32'(m_dout));
    check("valid",  32'(dout_valid_o),  32'(m_valid));
    check("ovf",    32'(overflow_o),    32'(m_ovf));
    check("udf",    32'(underflow_o),   32'(m_udf));
`ifdef FILO_STACK_PEEK_EN
    check("peek_valid", 32'(peek_valid_o), 32'(int'(peek_idx_i) < sz));
    check("peek_data",  32'(peek_data_o),
          (int'(peek_idx_i) < sz) ? 32'(q[sz-1-int'(peek_idx_i)]) : 32'd0);
`endif
  endtask

  // Apply one cycle of inputs, advance the model per the stack rules, check.
  task automatic step(input logic rst, input logic psh, input logic pp,
                      input logic [7:0] d, input logic clr);
    reset_i     = rst;
    push_i      = psh;
    pop_i       = pp;
    din_i       = d;
    clear_err_i = clr;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_dout  = 8'h00;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (clr) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (psh && pp) begin
        m_valid = 1'b1;
        if (q.size() == 0) m_dout = d;
        else begin
          m_dout = q[q.size()-1];
          q[q.size()-1] = d;
        end
      end else if (psh) begin
        if (q.size() == DEPTH) m_ovf = 1'b1;
        else q.push_back(d);
      end else if (pp) begin
        if (q.size() == 0) m_udf = 1'b1;
        else begin
          m_dout  = q.pop_back();
          m_valid = 1'b1;
        end
      end
    end
    check_all();
  endtask

  initial begin
    reset_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; din_i = 8'h00; clear_err_i = 1'b0;
`ifdef FILO_STACK_PEEK_EN
    peek_idx_i = 3'd0;
`endif
    q.delete();
    m_dout = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    #2;

    // Reset state
    step(1, 0, 0, 8'h00, 0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);

    // Basic LIFO order
    step(0, 1, 0, 8'h11, 0);
    step(0, 1, 0, 8'h22, 0);
    step(0, 1, 0, 8'h33, 0);
    check("lifo_cnt3", 32'(count_o), 32'd3);
    step(0, 0, 1, 8'h00, 0);
    check("lifo_pop1", 32'(dout_o), 32'h33);
    step(0, 0, 1, 8'h00, 0);
    check("lifo_pop2", 32'(dout_o), 32'h22);
    step(0, 0, 1, 8'h00, 0);
    check("lifo_pop3", 32'(dout_o), 32'h11);
    check("lifo_empty", 32'(empty_o), 32'd1);

    // Fill past full
    for (int i = 1; i <= 9; i++) step(0, 1, 0, 8'(i), 0);
    check("fill_full", 32'(full_o), 32'd1);
    check("fill_ovf",  32'(overflow_o), 32'd1);
    step(0, 0, 1, 8'h00, 0);
    check("fill_pop", 32'(dout_o), 32'h08);

    // Underflow and clear priority
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'h00, 0);
    check("udf_set", 32'(underflow_o), 32'd1);
    check("udf_novalid", 32'(dout_valid_o), 32'd0);
    step(0, 0, 0, 8'h00, 1);
    check("udf_clr", 32'(underflow_o), 32'd0);
    step(0, 0, 1, 8'h00, 1);
    check("udf_win", 32'(underflow_o), 32'd1);

    // Replace and bypass
    step(1, 0, 0, 8'h00, 0);
    step(0, 1, 0, 8'hA0, 0);
    step(0, 1, 0, 8'hA1, 0);
    step(0, 1, 1, 8'h5C, 0);
    check("repl_dout", 32'(dout_o), 32'hA1);
    check("repl_top",  32'(top_o),  32'h5C);
    check("repl_cnt",  32'(count_o), 32'd2);
    step(1, 0, 0, 8'h00, 0);
    step(0, 1, 1, 8'h77, 0);
    check("byp_dout", 32'(dout_o), 32'h77);
    check("byp_cnt",  32'(count_o), 32'd0);
    check("byp_udf",  32'(underflow_o), 32'd0);

    // Almost-full threshold and mid-sequence reset
    step(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      check("af_before", 32'(almost_full_o), 32'd0);
      step(0, 1, 0, 8'(8'h40 + i), 0);
    end
    check("af_rise", 32'(almost_full_o), 32'd1);
    step(0, 0, 1, 8'h00, 0);
    check("af_fall", 32'(almost_full_o), 32'd0);
    step(1, 1, 1, 8'hEE, 1);
    check("rst_mid_cnt",   32'(count_o), 32'd0);
    check("rst_mid_valid", 32'(dout_valid_o), 32'd0);

`ifdef FILO_STACK_PEEK_EN
    step(0, 1, 0, 8'h10, 0);
    step(0, 1, 0, 8'h20, 0);
    step(0, 1, 0, 8'h30, 0);
    peek_idx_i = 3'd0; #1;
    check("peek0", 32'(peek_data_o), 32'h30);
    peek_idx_i = 3'd2; #1;
    check("peek2", 32'(peek_data_o), 32'h10);
    peek_idx_i = 3'd3; #1;
    check("peek3_valid", 32'(peek_valid_o), 32'd0);
    check("peek3_data",  32'(peek_data_o), 32'd0);
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic r, ps, pp, cl;
      r  = ($urandom_range(0, 99) < 2);
      ps = ($urandom_range(0, 99) < 55);
      pp = ($urandom_range(0, 99) < 45);
      cl = ($urandom_range(0, 99) < 10);
`ifdef FILO_STACK_PEEK_EN
      peek_idx_i = 3'($urandom_range(0, 7));
`endif
      step(r, ps, pp, 8'($urandom), cl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
